noc_axilite_resp_bridge: RTL
============================

Name: noc_axilite_resp_bridge

Overview:
Response-side companion to the AXI-lite→NoC request bridge. Consumes NoC3 response messages (NC load/store memory acks) returned for requests the bridge issued on NoC2. Converts them into AXI-lite R and B channel responses toward the AXI-lite master. Sits between the chipset NoC3 router output and the master's R/B inputs; one response register per AXI channel.

Parameters:
AXI_DATA_WIDTH, 64, AXI-lite R data width; must be 32 or 64; rdata = first data flit[AXI_DATA_WIDTH-1:0].
CNT_WIDTH, 16, width of the dropped-message counter.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
noc3_valid_in  in  1  NoC3 flit valid
noc3_data_in  in  `NOC_DATA_WIDTH  NoC3 flit
noc3_ready_out  out  1  NoC3 flit accept
m_axi_rdata  out  AXI_DATA_WIDTH  read data
m_axi_rresp  out  `C_M_AXI_LITE_RESP_WIDTH  read response
m_axi_rvalid  out  1  read response valid
m_axi_rready  in  1  master accepts R
m_axi_bresp  out  `C_M_AXI_LITE_RESP_WIDTH  write response
m_axi_bvalid  out  1  write response valid
m_axi_bready  in  1  master accepts B
drop_count  out  CNT_WIDTH  unrecognised messages dropped

Behaviour:
- Reset (async, rst=1): state=IDLE, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, drop_count=0, remaining=0. Reset mid-message discards the partial message; upstream is reset by the same rst.
- Flit handshake: noc3_valid_in && noc3_ready_out. Header fields are decoded with `MSG_TYPE and `MSG_LENGTH (length = number of following data flits, 8 bits).
- IDLE, header type `MSG_TYPE_NC_LOAD_MEM_ACK: ready = !rvalid || rready. Length 0 → load R register next cycle: rdata=0, rresp=SLVERR(2'b10), rvalid=1, stay IDLE. Length L≥1 → remaining=L, go LDATA.
- IDLE, header type `MSG_TYPE_NC_STORE_MEM_ACK: ready = !bvalid || bready. Length 0 → bresp=OKAY(2'b00), bvalid=1 next cycle. Length L≥1 → remaining=L, go SDRAIN.
- IDLE, any other type: ready=1; drop_count increments (saturating at all-ones); L≥1 → remaining=L, go DROP; L=0 → stay IDLE.
- LDATA: ready=1. First data flit captured into rdata. Each accepted flit decrements remaining. On the flit with remaining==1: rresp=OKAY, rvalid=1 next cycle, go IDLE. Flits 2..L are discarded.
- SDRAIN: ready=1, consume L flits; on last, bvalid=1 with OKAY next cycle, go IDLE.
- DROP: ready=1, consume L flits, go IDLE; no AXI output.
- ready is combinational from noc3_data_in type in IDLE; this is permitted by the NoC val/rdy protocol.
- R/B registers hold rdata/rresp/bresp stable while valid && !ready. Clear valid on valid&&ready unless reloaded the same cycle. Back-to-back reload on the same cycle is allowed: new value, valid stays 1.
- Latency: header (L=0) or last data flit accepted in cycle N → valid high in cycle N+1. Sustained throughput is one response per (L+1) cycles.
- R and B are independent; a blocked B never stalls a load ack already inside LDATA. The load ack header itself is gated only by R.
- No valid-in → no state change. remaining never wraps; L=255 is legal.

Optional Feature:
NOC_AXILITE_RESP_DROP_CNT_EN: when defined, drop_count is implemented as above. When undefined, drop_count is tied to 0 and no counter register exists; unknown messages are still drained identically.

Test Plan:
- Load ack L=1, data 64'h0123_4567_89AB_CDEF, rready=1 → rvalid 1 cycle after data flit, rdata=64'h0123456789ABCDEF, rresp=2'b00; 2 cycles of ready=1.
- Store ack L=0, bready held 0 for 5 cycles; second store ack offered → bvalid=1, bresp=0 stable 5 cycles; noc3_ready_out=0 for second header until bready=1, then accepted the same cycle; bvalid stays 1.
- Load ack L=3 with data A,B,C → rdata=A, rvalid after third flit; B and C not visible.
- Load ack L=0 → rvalid, rresp=2'b10, rdata=0.
- Unknown type L=2 then store ack L=0 → 3 flits consumed, no R/B activity, then bvalid; drop_count=1 (0 with macro undefined).
- rst asserted asynchronously mid-LDATA (after 1 of 3 flits) → rvalid=0 and state IDLE immediately; next header is decoded correctly after release.

Source files
------------

// File: rtl/noc_axilite_resp_bridge_if.sv
// ============================================================================
// Module      : noc_axilite_resp_bridge_if
// Description : Bundles the NoC3 response flit port with the AXI-lite R and B
//               channels driven by noc_axilite_resp_bridge. The NoC message
//               field macros fall back to the chipset defaults when no
//               platform header has defined them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 29:22
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 37:30
`endif
`ifndef MSG_TYPE_NC_LOAD_MEM_ACK
`define MSG_TYPE_NC_LOAD_MEM_ACK 8'd26
`endif
`ifndef MSG_TYPE_NC_STORE_MEM_ACK
`define MSG_TYPE_NC_STORE_MEM_ACK 8'd27
`endif
`ifndef C_M_AXI_LITE_RESP_WIDTH
`define C_M_AXI_LITE_RESP_WIDTH 2
`endif

interface noc_axilite_resp_bridge_if #(
   parameter int AXI_DATA_WIDTH = 64
) ();
   logic                                noc3_valid_in;
   logic [`NOC_DATA_WIDTH-1:0]          noc3_data_in;
   logic                                noc3_ready_out;
   logic [AXI_DATA_WIDTH-1:0]           m_axi_rdata;
   logic [`C_M_AXI_LITE_RESP_WIDTH-1:0] m_axi_rresp;
   logic                                m_axi_rvalid;
   logic                                m_axi_rready;
   logic [`C_M_AXI_LITE_RESP_WIDTH-1:0] m_axi_bresp;
   logic                                m_axi_bvalid;
   logic                                m_axi_bready;

   // Bridge side: consumes NoC3 flits, produces R/B responses.
   modport slave (
      input  noc3_valid_in, noc3_data_in, m_axi_rready, m_axi_bready,
      output noc3_ready_out, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
             m_axi_bresp, m_axi_bvalid
   );

   // Environment side: NoC3 router plus AXI-lite master.
   modport master (
      output noc3_valid_in, noc3_data_in, m_axi_rready, m_axi_bready,
      input  noc3_ready_out, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
             m_axi_bresp, m_axi_bvalid
   );
endinterface

`default_nettype wire

// File: rtl/noc_axilite_resp_bridge.sv
// ============================================================================
// Module      : noc_axilite_resp_bridge
// Description : Turns NoC3 NC load/store memory acks into AXI-lite R and B
//               responses. One response register per AXI channel; unknown
//               messages are drained silently. Optional feature macro:
//               NOC_AXILITE_RESP_DROP_CNT_EN (enables the drop counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_axilite_resp_bridge #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int CNT_WIDTH      = 16
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   noc_axilite_resp_bridge_if.slave  bus,
   output logic [CNT_WIDTH-1:0]      drop_count
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LDATA  = 2'd1,
      S_SDRAIN = 2'd2,
      S_DROP   = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [7:0]                r_remaining;
   logic [7:0]                w_remaining_nxt;
   logic                      r_ld_first;
   logic                      w_ld_first_nxt;

   logic [AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                r_rresp;
   logic                      r_rvalid;
   logic [1:0]                r_bresp;
   logic                      r_bvalid;

   logic [7:0]                w_type;
   logic [7:0]                w_len;
   logic                      w_r_free;
   logic                      w_b_free;
   logic                      w_last;
   logic                      w_ready;
   logic                      w_r_load;
   logic [1:0]                w_rresp_nxt;
   logic                      w_rdata_zero;
   logic                      w_rdata_cap;
   logic                      w_b_load;
   logic                      w_drop_hit;

   assign w_type   = bus.noc3_data_in[`MSG_TYPE];
   assign w_len    = bus.noc3_data_in[`MSG_LENGTH];
   // A response register can take a new value if empty or being drained now.
   assign w_r_free = !r_rvalid || bus.m_axi_rready;
   assign w_b_free = !r_bvalid || bus.m_axi_bready;
   assign w_last   = (r_remaining == 8'd1);

   // State register; reset mid-message simply abandons the partial message.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= 8'd0;
         r_ld_first  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_ld_first  <= w_ld_first_nxt;
      end
   end

   // Header decode, data-flit counting and response-load requests.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_ld_first_nxt  = r_ld_first;
      w_ready         = 1'b1;
      w_r_load        = 1'b0;
      w_rresp_nxt     = RESP_OKAY;
      w_rdata_zero    = 1'b0;
      w_rdata_cap     = 1'b0;
      w_b_load        = 1'b0;
      w_drop_hit      = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Ack headers are only accepted when their response register can
            // take the result; each channel gates only its own headers.
            if (w_type == `MSG_TYPE_NC_LOAD_MEM_ACK) begin
               w_ready = w_r_free;
            end else if (w_type == `MSG_TYPE_NC_STORE_MEM_ACK) begin
               w_ready = w_b_free;
            end

            if (bus.noc3_valid_in && w_ready) begin
               if (w_type == `MSG_TYPE_NC_LOAD_MEM_ACK) begin
                  if (w_len == 8'd0) begin
                     // A load ack carrying no data is reported as an error.
                     w_r_load     = 1'b1;
                     w_rresp_nxt  = RESP_SLVERR;
                     w_rdata_zero = 1'b1;
                  end else begin
                     w_remaining_nxt = w_len;
                     w_ld_first_nxt  = 1'b1;
                     w_state_nxt     = S_LDATA;
                  end
               end else if (w_type == `MSG_TYPE_NC_STORE_MEM_ACK) begin
                  if (w_len == 8'd0) begin
                     w_b_load = 1'b1;
                  end else begin
                     w_remaining_nxt = w_len;
                     w_state_nxt     = S_SDRAIN;
                  end
               end else begin
                  w_drop_hit = 1'b1;
                  if (w_len != 8'd0) begin
                     w_remaining_nxt = w_len;
                     w_state_nxt     = S_DROP;
                  end
               end
            end
         end

         S_LDATA: begin
            if (bus.noc3_valid_in) begin
               w_remaining_nxt = r_remaining - 8'd1;
               w_ld_first_nxt  = 1'b0;
               // Only the first data flit carries the read data.
               w_rdata_cap     = r_ld_first;
               if (w_last) begin
                  w_r_load    = 1'b1;
                  w_rresp_nxt = RESP_OKAY;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_SDRAIN: begin
            if (bus.noc3_valid_in) begin
               w_remaining_nxt = r_remaining - 8'd1;
               if (w_last) begin
                  w_b_load    = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_DROP: begin
            if (bus.noc3_valid_in) begin
               w_remaining_nxt = r_remaining - 8'd1;
               if (w_last) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // R response register: load wins over drain so back-to-back keeps valid up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else begin
         if (w_rdata_zero) begin
            r_rdata <= '0;
         end else if (w_rdata_cap) begin
            r_rdata <= bus.noc3_data_in[AXI_DATA_WIDTH-1:0];
         end
         if (w_r_load) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rresp_nxt;
         end else if (r_rvalid && bus.m_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // B response register, same load-over-drain priority as R.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else begin
         if (w_b_load) begin
            r_bvalid <= 1'b1;
            r_bresp  <= RESP_OKAY;
         end else if (r_bvalid && bus.m_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
   logic [CNT_WIDTH-1:0] r_drop_count;

   // Saturating count of unrecognised message headers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_count <= '0;
      end else if (w_drop_hit && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
         r_drop_count <= r_drop_count + 1'b1;
      end
   end

   assign drop_count = r_drop_count;
`else
   logic w_unused_drop_hit;
   assign w_unused_drop_hit = w_drop_hit;
   assign drop_count        = '0;
`endif

   assign bus.noc3_ready_out = w_ready;
   assign bus.m_axi_rdata    = r_rdata;
   assign bus.m_axi_rresp    = r_rresp;
   assign bus.m_axi_rvalid   = r_rvalid;
   assign bus.m_axi_bresp    = r_bresp;
   assign bus.m_axi_bvalid   = r_bvalid;

endmodule

`default_nettype wire
